memory_dp_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences a `memory_dp` instance as FIFO storage. It provides valid/ready handshakes on its input and output sides and drives the memory write and read ports. It also hides the memory's one-cycle read latency behind a 2-entry output staging buffer, so the FIFO sustains one word per cycle in and out. It sits between a producer and a consumer; `memory_dp` is instantiated alongside it with `wr_clk` and `rd_clk` both tied to `clk`.

---
 rtl/memory_dp_fifo_ctrl.sv | 89 ++++++++
 tb/tb_memory_dp_fifo_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_dp_fifo_ctrl.sv
// FIFO controller that uses an external dual-port memory as storage. A 2-entry
// output stage hides the memory's one-cycle read latency for full throughput.
module memory_dp_fifo_ctrl #(
  parameter int num_mem_entries = 8,
  parameter int data_bit_width  = 32,
  parameter int addr_bit_width  = $clog2(num_mem_entries)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_bit_width-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [data_bit_width-1:0] out_data,
  output logic [addr_bit_width:0]   count,
  output logic                      mem_wr_en,
  output logic [addr_bit_width-1:0] mem_wr_addr,
  output logic [data_bit_width-1:0] mem_wr_data,
  output logic                      mem_rd_en,
  output logic [addr_bit_width-1:0] mem_rd_addr,
  input  logic [data_bit_width-1:0] mem_rd_data
);
  localparam int PW = addr_bit_width + 1;
  localparam logic [PW-1:0] FULL = PW'(num_mem_entries);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pop_ptr_q, pop_ptr_d;
  logic [1:0][data_bit_width-1:0] stage_q, stage_d;
  logic [1:0] stage_cnt_q, stage_cnt_d, cnt_after_pop;
  logic       inflight_q, inflight_d;
  logic       push, pop;

  always_comb begin
    count       = wr_ptr_q - pop_ptr_q;
    in_ready    = (count != FULL);
    out_valid   = (stage_cnt_q != 2'd0);
    out_data    = stage_q[0];
    push        = in_valid && in_ready && !flush;
    pop         = out_valid && out_ready && !flush;
    mem_wr_en   = push;
    mem_wr_addr = wr_ptr_q[addr_bit_width-1:0];
    mem_wr_data = in_data;
    // Stage slots plus the pending read never exceed two, so capture always fits.
    mem_rd_en   = !flush && (wr_ptr_q != rd_ptr_q) &&
                  ((({1'b0, stage_cnt_q} + {2'b00, inflight_q}) < 3'd2) || pop);
    mem_rd_addr = rd_ptr_q[addr_bit_width-1:0];
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(mem_rd_en);
    pop_ptr_d     = pop_ptr_q + PW'(pop);
    inflight_d    = mem_rd_en;
    stage_d       = stage_q;
    cnt_after_pop = stage_cnt_q - {1'b0, pop};
    stage_cnt_d   = cnt_after_pop;
    if (pop) stage_d[0] = stage_q[1];
    if (inflight_q) begin
      stage_d[cnt_after_pop[0]] = mem_rd_data;
      stage_cnt_d               = cnt_after_pop + 2'd1;
    end
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pop_ptr_d   = '0;
      stage_cnt_d = '0;
      inflight_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_ptr_q   <= '0;
      stage_q     <= '0;
      stage_cnt_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      stage_q     <= stage_d;
      stage_cnt_q <= stage_cnt_d;
      inflight_q  <= inflight_d;
    end
  end
endmodule

// File: tb/tb_memory_dp_fifo_ctrl.sv
// Bench for memory_dp_fifo_ctrl: behavioural memory plus a queue scoreboard,
// directed latency/flush/reset steps and randomized backpressure.
module tb_memory_dp_fifo_ctrl;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] mem [N];

  memory_dp_fifo_ctrl #(.num_mem_entries(N), .data_bit_width(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory: write and registered read at the same edge.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  int checks = 0;
  int failures = 0;

  // Reference: queue of words accepted and not yet delivered.
  logic [DW-1:0] q[$];
  int            npop = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          s_push, s_pop, s_ov, s_rd_en, s_wr_en, s_in_ready;
  logic [AW-1:0] s_wr_addr;
  logic [DW-1:0] s_data;
  logic [AW:0]   s_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    stall_prev = 1'b0;
  endtask

  // One clock: sample just before the edge, check against the model, then advance.
  task automatic cyc();
    logic exp_push;
    #1;
    s_ov = out_valid; s_data = out_data; s_cnt = count; s_rd_en = mem_rd_en;
    s_wr_en = mem_wr_en; s_wr_addr = mem_wr_addr; s_in_ready = in_ready;
    chk("count", count, q.size());
    chk("in_ready", in_ready, q.size() != N);
    exp_push = in_valid && (q.size() != N) && !flush;
    chk("wr_en", mem_wr_en, exp_push);
    if (exp_push) chk("wr_data", mem_wr_data, in_data);
    if (flush) chk("rd_en_flush", mem_rd_en, 0);
    if (out_valid) chk("valid_has_data", q.size() != 0, 1);
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_data);
    end
    s_push = exp_push;
    s_pop  = out_valid && out_ready && !flush && (q.size() != 0);
    if (s_pop) chk("out_data", out_data, q[0]);
    stall_prev = out_valid && !out_ready && !flush;
    prev_data  = out_data;
    @(posedge clk);
    if (flush) model_clear();
    else begin
      if (s_push) q.push_back(in_data);
      if (s_pop) begin void'(q.pop_front()); npop++; end
    end
    @(negedge clk);
  endtask

  // Single word into an empty FIFO: read issued next cycle, visible two edges later.
  task automatic lat_test(input logic [DW-1:0] v, input string tg);
    out_ready = 1'b0; in_valid = 1'b1; in_data = v;
    cyc(); chk({tg, "_accept"}, s_push, 1);
    in_valid = 1'b0;
    cyc(); chk({tg, "_rd_issue"}, s_rd_en, 1); chk({tg, "_ov_e1"}, s_ov, 0);
    cyc(); chk({tg, "_ov_e2"}, s_ov, 0);
    cyc(); chk({tg, "_ov_e3"}, s_ov, 1); chk({tg, "_head"}, s_data, v);
    out_ready = 1'b1;
    cyc(); chk({tg, "_pop"}, s_pop, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int first_acc, first_ov, nxt, k;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Fill to capacity, then offer a word that must be refused.
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = i;
      cyc(); chk("fill_addr", s_wr_addr, i);
    end
    in_data = 32'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("full_block", s_wr_en, 0); chk("full_ready", s_in_ready, 0);
      chk("full_cnt", s_cnt, N);
    end
    in_valid = 1'b0;

    // Drain: one word per cycle, continuous valid.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      cyc(); chk("drain_valid", s_ov, 1); chk("drain_data", s_data, i);
    end
    cyc(); chk("drain_empty_valid", s_ov, 0); chk("drain_empty_cnt", s_cnt, 0);
    out_ready = 1'b0;

    lat_test(32'h3C, "lat");

    // Streaming 0..31 with consumer always ready.
    npop = 0; first_acc = -1; first_ov = -1; nxt = 0; out_ready = 1'b1;
    for (k = 0; k < 300 && npop < 32; k++) begin
      in_valid = (nxt < 32); in_data = nxt;
      cyc();
      if (s_push) begin if (first_acc < 0) first_acc = k; nxt++; end
      if (s_ov && first_ov < 0) first_ov = k;
      if (first_ov >= 0) chk("stream_cont", s_pop, 1);
      chk("stream_cnt_le3", s_cnt <= 3, 1);
    end
    chk("stream_latency", first_ov - first_acc, 3);
    chk("stream_done", npop, 32);
    in_valid = 1'b0;

    // Random backpressure over 64 words.
    npop = 0; nxt = 0;
    for (k = 0; k < 3000 && npop < 64; k++) begin
      in_valid = (nxt < 64); in_data = nxt;
      out_ready = $urandom_range(0, 1);
      cyc();
      if (s_push) nxt++;
    end
    chk("bp_done", npop, 64);
    chk("bp_empty", q.size(), 0);
    in_valid = 1'b0; out_ready = 1'b0;

    // Flush with five words held and a read in flight.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 32'h60 + i; cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    out_ready = 1'b1;
    cyc(); chk("fl_pre_pop", s_pop, 1); chk("fl_pre_rd", s_rd_en, 1);
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    cyc(); chk("fl_cnt_before", s_cnt, 5); chk("fl_wr_blocked", s_wr_en, 0);
    chk("fl_rd_blocked", s_rd_en, 0);
    flush = 1'b0; in_valid = 1'b0;
    cyc(); chk("fl_cnt_after", s_cnt, 0); chk("fl_ov_after", s_ov, 0);
    lat_test(32'hA5, "flush_lat");

    // Asynchronous reset mid-stream with four words held.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h40 + i; cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    chk("rs_cnt_before", s_cnt, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_out_valid", out_valid, 0);
    chk("rs_count", count, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_wr_en", mem_wr_en, 0);
    chk("rs_rd_en", mem_rd_en, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    lat_test(32'h11, "rst_lat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
